// File: rtl/sseg_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg
//
// Shared constants for the seven-segment scan driver.
//
// Contents:
//   NUM_DIGITS          number of multiplexed digits on the display
//   IDX_W               width of the digit index
//   SEG_HEX_0..SEG_HEX_F  active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK           all segments off
//   AN_OFF              all anodes off
//   digit_anode()       active-low one-cold anode pattern for a digit index
// ---------------------------------------------------------------------------
package sseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    // Segment patterns for a common-anode display: a 0 lights the segment.
    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    localparam logic [6:0]            SEG_BLANK = 7'b1111111;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'b1111;

    // Anodes are active-low, so the selected digit is the single 0 bit.
    function automatic logic [NUM_DIGITS-1:0] digit_anode(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] onehot;
        onehot = '0;
        onehot[idx] = 1'b1;
        return ~onehot;
    endfunction

endpackage : sseg_pkg

// File: rtl/sseg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// sseg_scan_driver_if
//
// Bundle between the value producer (e.g. the motion detector) and the
// seven-segment scan driver, plus the pins that go to the display.
//
// Signals:
//   value       16-bit hex value to show, digit0 = value[3:0] (rightmost)
//   dp_in       per-digit decimal point request, 1 = on
//   enable      1 = scan and display, 0 = blank and freeze the scan
//   an          digit anodes, active-low, an[0] = rightmost
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   frame_done  one-cycle pulse when digit 3 completes its slot
//
// Transfer semantics: there is no valid/ready handshake. value/dp_in are a
// level-sampled stream; the driver samples them only at the edge that ends
// the last digit's slot, and frame_done in the following cycle marks that
// the sample was taken. The producer may change value at any time.
//
// Modports:
//   master  the value producer / observer of the display pins
//   slave   the scan driver
// ---------------------------------------------------------------------------
interface sseg_scan_driver_if;
    import sseg_pkg::*;

    logic [15:0]           value;
    logic [NUM_DIGITS-1:0] dp_in;
    logic                  enable;
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_done;

    modport master (
        output value,
        output dp_in,
        output enable,
        input  an,
        input  seg,
        input  dp,
        input  frame_done
    );

    modport slave (
        input  value,
        input  dp_in,
        input  enable,
        output an,
        output seg,
        output dp,
        output frame_done
    );

endinterface : sseg_scan_driver_if

// File: rtl/hex_to_sseg.sv
// ---------------------------------------------------------------------------
// hex_to_sseg
//
// Combinational 4-bit hex nibble to active-low seven-segment decoder.
//
// Ports:
//   hex  in   4-bit nibble
//   seg  out  segment pattern {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule : hex_to_sseg

// File: rtl/sseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sseg_scan_driver
//
// Time-multiplexed 4-digit seven-segment driver for a common-anode display.
// Each digit owns a slot of DIGIT_PERIOD cycles; the first BLANK_CYCLES of
// every slot keep all anodes off so the previous digit's segments never
// ghost onto the next one. The displayed value is copied into a shadow
// register only at the end of the last digit's slot, so one frame always
// shows a single consistent value.
//
// Parameters:
//   DIGIT_PERIOD  cycles per digit slot, must be >= BLANK_CYCLES+1
//   BLANK_CYCLES  blank cycles at the start of each slot (0 allowed)
//
// Ports:
//   clk    in     system clock, rising edge
//   reset  in     synchronous reset, active-low
//   bus    slave  value/dp_in/enable in, an/seg/dp/frame_done out
//
// Outputs are registered from the current-cycle state, so every display
// pin lags the timer/index by one cycle.
// ---------------------------------------------------------------------------
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int DIGIT_PERIOD = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic               clk,
    input  logic               reset,
    sseg_scan_driver_if.slave  bus
);

    // A one-cycle slot still needs a 1-bit timer.
    localparam int TIMER_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(DIGIT_PERIOD - 1);
    localparam logic [TIMER_W-1:0] TIMER_BLANK = TIMER_W'(BLANK_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE     = IDX_W'(1);

    // -----------------------------------------------------------------
    // State
    // -----------------------------------------------------------------
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [15:0]           shadow_value_q, shadow_value_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    // -----------------------------------------------------------------
    // Digit decode of the currently scanned shadow nibble
    // -----------------------------------------------------------------
    logic [3:0] cur_nibble;
    logic [6:0] cur_seg;

    assign cur_nibble = shadow_value_q[{idx_q, 2'b00} +: 4];

    hex_to_sseg u_hex_to_sseg (
        .hex (cur_nibble),
        .seg (cur_seg)
    );

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    logic slot_end;
    logic display_on;

    always_comb begin
        timer_d        = timer_q;
        idx_d          = idx_q;
        shadow_value_d = shadow_value_q;
        shadow_dp_d    = shadow_dp_q;
        frame_done_d   = 1'b0;

        slot_end = (timer_q == TIMER_LAST);

        // With enable low everything freezes, so a re-enable picks up the
        // same slot at the same timer count.
        if (bus.enable) begin
            if (slot_end) begin
                timer_d = '0;
                idx_d   = idx_q + IDX_ONE;
                // Frame boundary: the only point where new input is taken.
                if (idx_q == IDX_LAST) begin
                    shadow_value_d = bus.value;
                    shadow_dp_d    = bus.dp_in;
                    frame_done_d   = 1'b1;
                end
            end else begin
                timer_d = timer_q + TIMER_ONE;
            end
        end

        display_on = bus.enable && (timer_q >= TIMER_BLANK);

        if (display_on) begin
            an_d  = digit_anode(idx_q);
            seg_d = cur_seg;
            dp_d  = ~shadow_dp_q[idx_q];
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    // -----------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer_q        <= '0;
            idx_q          <= '0;
            shadow_value_q <= '0;
            shadow_dp_q    <= '0;
            an_q           <= AN_OFF;
            seg_q          <= SEG_BLANK;
            dp_q           <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            timer_q        <= timer_d;
            idx_q          <= idx_d;
            shadow_value_q <= shadow_value_d;
            shadow_dp_q    <= shadow_dp_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule : sseg_scan_driver

// File: tb/tb_sseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_driver
//
// Directed bench for sseg_scan_driver with DIGIT_PERIOD=8, BLANK_CYCLES=2.
// The driver pushes the hand-derived expected pin state {an,seg,dp,frame_done}
// for every clock edge; the monitor pops one entry per cycle on the falling
// edge and compares it with the display pins.
// ---------------------------------------------------------------------------
module tb_sseg_scan_driver;

    // Hand-written active-low segment patterns {g,f,e,d,c,b,a}.
    localparam logic [6:0] S_0   = 7'b1000000;
    localparam logic [6:0] S_1   = 7'b1111001;
    localparam logic [6:0] S_3   = 7'b0110000;
    localparam logic [6:0] S_5   = 7'b0010010;
    localparam logic [6:0] S_9   = 7'b0010000;
    localparam logic [6:0] S_A   = 7'b0001000;
    localparam logic [6:0] S_C   = 7'b1000110;
    localparam logic [6:0] S_E   = 7'b0000110;
    localparam logic [6:0] S_F   = 7'b0001110;
    localparam logic [6:0] S_OFF = 7'b1111111;

    // {an, seg, dp, frame_done} with everything dark.
    localparam logic [12:0] EXP_DARK = {4'b1111, 7'b1111111, 1'b1, 1'b0};

    // -----------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sseg_scan_driver_if sif ();

    sseg_scan_driver #(
        .DIGIT_PERIOD (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    // -----------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------
    logic [12:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    initial begin
        logic [12:0] e;
        logic [12:0] got;
        string       t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                got = {sif.an, sif.seg, sif.dp, sif.frame_done};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                             t, got[12:9], got[8:2], got[1], got[0],
                             e[12:9], e[8:2], e[1], e[0]);
                end
            end
        end
    end

    // -----------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------
    function automatic logic [3:0] an_for(input int d);
        case (d)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // One clock edge; the expectation describes the pins after that edge.
    task automatic tick(input logic [12:0] e, input string t);
        @(posedge clk);
        exp_q.push_back(e);
        tag_q.push_back(t);
        #1;
    endtask

    // Cycles j0..j1 (1-based) of digit d's slot: cycles 1-2 are blank,
    // 3-8 show the digit, and cycle 8 of digit 3 carries frame_done.
    task automatic run_slot(input int d, input logic [6:0] s, input logic dp_on,
                            input int j0, input int j1, input string tag);
        for (int j = j0; j <= j1; j++) begin
            if (j <= 2)
                tick(EXP_DARK, $sformatf("%s_d%0d_c%0d", tag, d, j));
            else
                tick({an_for(d), s, ~dp_on, (d == 3 && j == 8)},
                     $sformatf("%s_d%0d_c%0d", tag, d, j));
        end
    endtask

    task automatic run_frame(input logic [27:0] segs, input logic [3:0] dps, input string tag);
        for (int d = 0; d < 4; d++)
            run_slot(d, segs[7*d +: 7], dps[d], 1, 8, tag);
    endtask

    // -----------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------
    initial begin
        reset      = 1'b0;
        sif.value  = 16'hFFFF;
        sif.dp_in  = 4'b0000;
        sif.enable = 1'b1;

        // Reset held: pins dark, no frame_done.
        repeat (5) tick(EXP_DARK, "reset_hold");

        // Frame 1 shows the cleared shadow, value 1111 is latched at its end.
        reset     = 1'b1;
        sif.value = 16'h1111;
        run_frame({S_0, S_0, S_0, S_0}, 4'b0000, "f1_zero");

        // Frame 2 shows 1111; 0000 is queued for frame 3.
        sif.value = 16'h0000;
        run_frame({S_1, S_1, S_1, S_1}, 4'b0000, "f2_ones");

        // Frame 3: value flips to 1111 in digit 1, frame stays all '0'.
        run_slot(0, S_0, 1'b0, 1, 8, "f3_tear");
        run_slot(1, S_0, 1'b0, 1, 4, "f3_tear");
        sif.value = 16'h1111;
        run_slot(1, S_0, 1'b0, 5, 8, "f3_tear");
        run_slot(2, S_0, 1'b0, 1, 8, "f3_tear");
        run_slot(3, S_0, 1'b0, 1, 8, "f3_tear");

        // Frame 4 shows the new value; FA50 with dp on digit 2 is queued.
        sif.value = 16'hFA50;
        sif.dp_in = 4'b0100;
        run_frame({S_1, S_1, S_1, S_1}, 4'b0000, "f4_ones");

        // Frame 5: FA50 with a 10-cycle enable drop at timer 4 of digit 2.
        sif.value = 16'h3C9E;
        sif.dp_in = 4'b1001;
        run_slot(0, S_0, 1'b0, 1, 8, "f5_fa50");
        run_slot(1, S_5, 1'b0, 1, 8, "f5_fa50");
        run_slot(2, S_A, 1'b1, 1, 4, "f5_fa50");
        sif.enable = 1'b0;
        repeat (10) tick(EXP_DARK, "f5_disabled");
        sif.enable = 1'b1;
        run_slot(2, S_A, 1'b1, 5, 8, "f5_resume");
        run_slot(3, S_F, 1'b0, 1, 8, "f5_fa50");

        // Frame 6: 3C9E, aborted by a one-cycle reset inside digit 3.
        run_slot(0, S_E, 1'b1, 1, 8, "f6_3c9e");
        run_slot(1, S_9, 1'b0, 1, 8, "f6_3c9e");
        run_slot(2, S_C, 1'b0, 1, 8, "f6_3c9e");
        run_slot(3, S_3, 1'b1, 1, 4, "f6_3c9e");
        reset = 1'b0;
        tick(EXP_DARK, "f6_reset");
        reset = 1'b1;

        // Restart from digit 0 with the cleared shadow, then 3C9E again.
        run_frame({S_0, S_0, S_0, S_0}, 4'b0000, "f7_restart");
        run_frame({S_3, S_C, S_9, S_E}, 4'b1001, "f8_3c9e");

        // Let the monitor consume the last entry.
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sseg_scan_driver

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
Time-multiplexed 4-digit seven-segment driver, directly downstream of the motion detector. Consumes its 16-bit display value (e.g. 16'h1111 for MOTION, 16'h0000 for STABLE) and drives the board's common-anode display with active-low anodes and segments. The value is latched once per frame so a frame never mixes digits from two different values. Anti-ghosting blank time is inserted at each digit change.

Parameters:
DIGIT_PERIOD, 100_000, clock cycles per digit slot (1 ms at 100 MHz); must be >= BLANK_CYCLES+1
BLANK_CYCLES, 1_000, cycles at the start of each slot with all anodes off; 0 allowed

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
value  input  16  hex value to display; digit0 = value[3:0] (rightmost)
dp_in  input  4  decimal-point request per digit, 1 = on; dp_in[0] = rightmost
enable  input  1  1 = scan and display; 0 = blank and freeze scan
an  output  4  digit anodes, active-low; an[0] = rightmost
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
frame_done  output  1  1-cycle pulse each time digit 3 completes its slot

Behaviour:
- All logic on rising clk. Reset is synchronous and active-low: when reset==0 at an edge, the next state is an=4'b1111, seg=7'b1111111, dp=1, frame_done=0, idx=0, timer=0, shadow_value=0, shadow_dp=0. Reset mid-frame aborts the frame, with no frame_done.
- State: timer (0..DIGIT_PERIOD-1), idx (2 bits), shadow_value[15:0], shadow_dp[3:0].
- Advance when enable==1:
  - timer <= timer+1.
  - At timer==DIGIT_PERIOD-1: timer <= 0 and idx <= idx+1 (mod 4).
  - If idx==3 at that wrap, also shadow_value <= value, shadow_dp <= dp_in, and frame_done <= 1 on the next cycle. frame_done is 0 otherwise.
- enable==0: timer, idx and shadow registers hold; no frame_done. Re-enable resumes the same slot at the held timer count.
- Outputs are registered and computed from the current-cycle state (1-cycle latency).
  - Display is active when enable==1 and timer >= BLANK_CYCLES.
  - While active: an = ~(4'b0001 << idx), seg = hex decode of shadow_value[4*idx+3 : 4*idx], dp = ~shadow_dp[idx].
  - Otherwise: an=4'b1111, seg=7'b1111111, dp=1.
- After reset the first frame shows shadow contents (all '0'). The first external value appears in the frame after the first frame_done.
- value changes inside a frame have no effect until the next frame boundary.
- Hex decode (seg, {g..a}, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Timer width: $clog2(DIGIT_PERIOD). No overflow is possible because the timer wraps at DIGIT_PERIOD-1.

Decomposition:
- Shared package (sseg_pkg):
  - NUM_DIGITS=4
  - the 16 hex segment constants
  - SEG_BLANK=7'b1111111, AN_OFF=4'b1111
- One sub-module: hex_to_sseg, a combinational 4-bit to 7-bit decoder built from the package constants.
- Timer, index, shadow registers and output registers remain in sseg_scan_driver.

Test Plan:
(All scenarios use DIGIT_PERIOD=8, BLANK_CYCLES=2.)
1. Hold reset=0 for 5 cycles with value=16'hFFFF and enable=1 -> an=1111, seg=1111111, dp=1, frame_done=0 every cycle. Release reset -> first frame shows seg=1000000 on each digit.
2. value=16'h1111 from reset release -> frame 1 shows '0'; frame_done pulses once at cycle 32. Frame 2:
   - an sequence 1110, 1101, 1011, 0111, each low for 6 cycles preceded by 2 cycles of 1111
   - seg=1111001 throughout
3. Tearing check: value 16'h0000 -> 16'h1111 during digit 1 of a frame -> digits 2 and 3 of that frame still 1000000; the following frame shows 1111001 on all digits.
4. value=16'hFA50, dp_in=4'b0100 -> digit0 1000000, digit1 0010010, digit2 0001000 with dp=0, digit3 0001110; dp=1 on all other digits.
5. enable=0 at timer=4 of digit 2 for 10 cycles -> an=1111 from the next cycle and no frame_done. After re-enable, digit 2 shows for the remaining 4 active cycles (1 cycle output latency), then digit 3 follows.
6. reset=0 for 1 cycle during digit 3 -> outputs at reset values the next cycle, no frame_done, shadow cleared. Scan restarts at digit 0 displaying '0'.
